// File: rtl/reg_pkg.sv
// Shared register-file definitions: geometry, reserved addresses and loader states.
package reg_pkg;

    localparam int REG_PW      = 4;
    localparam int REG_DW      = 8;
    localparam int STATUS_ADDR = 3;
    localparam int ACC_ADDR    = 0;

    typedef logic [REG_PW-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } ld_state_t;

endpackage

// File: rtl/reg_addr_seq.sv
// Loader address sequencing: start-address fixup and wrap/skip increment.
// Pure combinational so it can be unit tested on its own.
module reg_addr_seq
    import reg_pkg::*;
#(
    parameter int PW        = REG_PW,
    parameter int SKIP_EN   = 1,
    parameter int SKIP_ADDR = STATUS_ADDR
) (
    input  logic [PW-1:0] first_addr,
    input  logic [PW-1:0] cur_addr,
    output logic [PW-1:0] start_addr,
    output logic [PW-1:0] next_addr
);

    localparam logic [PW-1:0] SKIP_A    = PW'(SKIP_ADDR);
    localparam logic [PW-1:0] SKIP_NEXT = SKIP_A + PW'(1);
    localparam bit            SKIP_ON   = (SKIP_EN != 0);

    logic [PW-1:0] inc_addr;

    // Both the start and the increment land one past the skipped slot, so a
    // skip never costs a byte or a cycle.
    always_comb begin
        inc_addr   = cur_addr + PW'(1);
        start_addr = (SKIP_ON && (first_addr == SKIP_A)) ? SKIP_NEXT : first_addr;
        next_addr  = (SKIP_ON && (inc_addr == SKIP_A))   ? SKIP_NEXT : inc_addr;
    end

endmodule

// File: rtl/reg_loader.sv
// Stream-to-register-file preloader: writes a block of consecutive registers
// from a valid/ready byte stream, stepping over the status register.
//
// state | meaning
// IDLE  | waiting for go; parameters latched on go
// LOAD  | accepting bytes, one write issued per transfer
// FLUSH | last write on the port, no more bytes accepted
// DONE  | one-cycle done pulse
module reg_loader
    import reg_pkg::*;
#(
    parameter int PW        = REG_PW,
    parameter int SKIP_EN   = 1,
    parameter int SKIP_ADDR = STATUS_ADDR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [PW-1:0] first_addr,
    input  logic [PW:0]   count,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    dat_in,
    output logic          busy,
    output logic          done,
    output logic [7:0]    checksum
);

    localparam int          NREG    = 2 ** PW;
    localparam logic [PW:0] MAX_CNT = (PW+1)'(NREG - ((SKIP_EN != 0) ? 1 : 0));

    ld_state_t     state;
    logic [PW-1:0] addr;
    logic [PW-1:0] start_addr;
    logic [PW-1:0] next_addr;
    logic [PW:0]   remaining;
    logic [PW:0]   eff_count;
    logic          xfer;

    reg_addr_seq #(
        .PW        (PW),
        .SKIP_EN   (SKIP_EN),
        .SKIP_ADDR (SKIP_ADDR)
    ) u_addr_seq (
        .first_addr (first_addr),
        .cur_addr   (addr),
        .start_addr (start_addr),
        .next_addr  (next_addr)
    );

    // With the skip active there is one fewer writable slot than NREG.
    assign eff_count = (count > MAX_CNT) ? MAX_CNT : count;

    // Handshake and status decode from the state register only, never from in_valid.
    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign xfer     = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            dat_in    <= '0;
            checksum  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        addr      <= start_addr;
                        remaining <= eff_count;
                        checksum  <= '0;
                        state     <= (eff_count != '0) ? LOAD : DONE;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= addr;
                        dat_in    <= in_data;
                        checksum  <= checksum ^ in_data;
                        addr      <= next_addr;
                        remaining <= remaining - (PW+1)'(1);
                        if (remaining == (PW+1)'(1)) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_loader.sv
// Scoreboard bench for reg_loader: stimulus queues expected writes/done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_reg_loader;

    typedef struct {
        bit         is_done;
        logic [3:0] a;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [3:0] first_addr;
    logic [4:0] count;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] dat_in;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    exp_t       sb[$];
    int         nchk = 0;
    int         nerr = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_acc_cyc = 0;
    logic [7:0] data_v[16];
    logic [3:0] addr_v[16];

    reg_loader dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .first_addr (first_addr),
        .count      (count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .dat_in     (dat_in),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every wr_en or done must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (wr_en) begin
                if (sb.size() == 0) begin
                    chk("spurious_wr_en", {28'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("wr_kind", 32'(e.is_done), 32'd0);
                    chk("wr_addr", 32'(wr_addr), 32'(e.a));
                    chk("wr_data", 32'(dat_in), 32'(e.d));
                end
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", 32'(e.is_done), 32'd1);
                    chk("done_checksum", 32'(checksum), 32'(e.d));
                end
            end
        end
    end

    task automatic run_load(input logic [3:0] fa, input logic [4:0] cnt, input int offered,
                            input int nexp, input int gap, input bit glitch_go, input string tag);
        int         accepted = 0;
        int         snap;
        int         go_cyc;
        int         t;
        logic [7:0] cs = 8'h00;
        exp_t       e;
        @(posedge clk); #1;
        go = 1'b1; first_addr = fa; count = cnt;
        go_cyc = cyc;
        snap = done_cnt;
        if (nexp == 0) begin
            e.is_done = 1'b1; e.a = 4'd0; e.d = 8'h00;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 0; i < offered; i++) begin
            in_valid = 1'b1;
            in_data  = data_v[i];
            if (accepted >= nexp) begin
                for (int k = 0; k < 4; k++) begin
                    chk({tag, "_extra_not_ready"}, 32'(in_ready), 32'd0);
                    @(posedge clk); #1;
                end
            end else begin
                t = 0;
                while (!in_ready && t < 10) begin
                    @(posedge clk); #1;
                    t++;
                end
                if (!in_ready) begin
                    chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
                end else begin
                    e.is_done = 1'b0; e.a = addr_v[accepted]; e.d = data_v[i];
                    sb.push_back(e);
                    cs = cs ^ data_v[i];
                    accepted++;
                    last_acc_cyc = cyc;
                    if (accepted == nexp) begin
                        e.is_done = 1'b1; e.a = 4'd0; e.d = cs;
                        sb.push_back(e);
                    end
                end
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            if (i < offered - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk({tag, "_busy_in_gap"}, 32'(busy), 32'd1);
                    if (glitch_go && g == 1) begin
                        go = 1'b1; first_addr = 4'd9; count = 5'd1;
                    end else begin
                        go = 1'b0;
                    end
                    @(posedge clk); #1;
                end
                go = 1'b0;
            end
        end
        t = 0;
        while (done_cnt == snap && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != snap), 32'd1);
        if (nexp > 0) chk({tag, "_done_latency"}, 32'(done_cyc - last_acc_cyc), 32'd2);
        else          chk({tag, "_done_latency"}, 32'(done_cyc - go_cyc), 32'd1);
        chk({tag, "_accepted"}, 32'(accepted), 32'(nexp));
        chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_checksum_held"}, 32'(checksum), 32'(cs));
        @(posedge clk); #1;
        chk({tag, "_single_done"}, 32'(done_cnt - snap), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        reset = 1'b1; go = 1'b0; first_addr = 4'd0; count = 5'd0;
        in_valid = 1'b0; in_data = 8'h00;
        #12;
        chk("reset_outputs", {in_ready, wr_en, busy, done, wr_addr, dat_in, checksum},
            32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // basic: R4..R6, checksum 0x11^0x22^0x33 = 0x00
        data_v[0] = 8'h11; data_v[1] = 8'h22; data_v[2] = 8'h33;
        addr_v[0] = 4'd4;  addr_v[1] = 4'd5;  addr_v[2] = 4'd6;
        run_load(4'd4, 5'd3, 3, 3, 0, 1'b0, "basic");

        // wrap 15 -> 0
        data_v[0] = 8'hA0; data_v[1] = 8'hA1; data_v[2] = 8'hA2; data_v[3] = 8'hA3;
        addr_v[0] = 4'd14; addr_v[1] = 4'd15; addr_v[2] = 4'd0;  addr_v[3] = 4'd1;
        run_load(4'd14, 5'd4, 4, 4, 0, 1'b0, "wrap");

        // skip R3: R2 then R4
        data_v[0] = 8'h5A; data_v[1] = 8'h0F;
        addr_v[0] = 4'd2;  addr_v[1] = 4'd4;
        run_load(4'd2, 5'd2, 2, 2, 0, 1'b0, "skip");

        // clamp: 15 of 16 accepted, R3 skipped
        for (int i = 0; i < 16; i++) data_v[i] = 8'h30 + 8'(i);
        for (int i = 0; i < 15; i++) addr_v[i] = (i < 3) ? 4'(i) : 4'(i + 1);
        run_load(4'd0, 5'd16, 16, 15, 0, 1'b0, "clamp");

        // stall with ignored go; start at R3 is fixed up to R4
        data_v[0] = 8'hC3; data_v[1] = 8'h3C;
        addr_v[0] = 4'd4;  addr_v[1] = 4'd5;
        run_load(4'd3, 5'd2, 2, 2, 5, 1'b1, "stall");

        // zero count: checksum must be cleared from 0xFF
        run_load(4'd7, 5'd0, 0, 0, 0, 1'b0, "zero");

        // reset mid-load after one of three bytes
        snap = done_cnt;
        @(posedge clk); #1;
        go = 1'b1; first_addr = 4'd8; count = 5'd3;
        @(posedge clk); #1;
        go = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        chk("rst_ready_before", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_write_before", {23'd0, wr_en, wr_addr, 4'd0}, {23'd0, 1'b1, 4'd8, 4'd0});
        chk("rst_data_before", 32'(dat_in), 32'h77);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_clear", {in_ready, wr_en, busy, done, wr_addr, dat_in, checksum},
            32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt - snap), 32'd0);
        chk("rst_idle", 32'(busy), 32'd0);

        data_v[0] = 8'h01; data_v[1] = 8'h02; data_v[2] = 8'h04;
        addr_v[0] = 4'd10; addr_v[1] = 4'd11; addr_v[2] = 4'd12;
        run_load(4'd10, 5'd3, 3, 3, 0, 1'b0, "after_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
